// File: rtl/burst_resp_pkg.sv
// Shared types and constants for the burst memory responder.
package burst_resp_pkg;

    // Responder control states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WR   = 2'd1,
        RD   = 2'd2,
        DONE = 2'd3
    } state_e;

    // Beats between bubble cycles when the gap option is built in.
    localparam int unsigned GAP_INTERVAL = 8;
    localparam int unsigned GAP_CNT_BITS = $clog2(GAP_INTERVAL);

endpackage

// File: rtl/burst_resp_ram.sv
// Simple dual-port synchronous RAM: one write port, one read port, read latency 1.
// The array itself is never reset; only the read data register is.
module burst_resp_ram #(
    parameter int unsigned DATA_BITS = 16,
    parameter int unsigned ADDR_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [DATA_BITS-1:0] wdata,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [DATA_BITS-1:0] rdata
);

    localparam int unsigned DEPTH = 1 << ADDR_BITS;

    logic [DATA_BITS-1:0] mem [DEPTH];
    logic [DATA_BITS-1:0] rdata_q;

    // Write port.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port; the output register holds its value while re is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/burst_mem_responder.sv
// Responder side of a burst read/write interface backed by an internal RAM.
// Optional build macro BURST_RESP_GAP_EN: insert one bubble cycle after every
// GAP_INTERVAL-th beat of a burst (only when further beats remain).
module burst_mem_responder
    import burst_resp_pkg::*;
#(
    parameter int unsigned MEM_DATA_BITS = 16,
    parameter int unsigned ADDR_BITS     = 24,
    parameter int unsigned BURST_BITS    = 10,
    parameter int unsigned DEPTH_BITS    = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     wr_burst_req,
    input  logic [BURST_BITS-1:0]    wr_burst_len,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,
    output logic                     wr_burst_data_req,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     wr_burst_finish,
    input  logic                     rd_burst_req,
    input  logic [BURST_BITS-1:0]    rd_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    output logic                     rd_burst_data_valid,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    output logic                     rd_burst_finish
);

    state_e                  state_q, state_d;
    logic [DEPTH_BITS-1:0]   addr_q, addr_d;
    logic [BURST_BITS-1:0]   left_q, left_d;
    logic                    wr_req_q, wr_req_d;
    logic                    rd_re_q, rd_re_d;
    logic                    wr_fin_q, wr_fin_d;
    logic                    rd_fin_q, rd_fin_d;
    logic                    rd_valid_q;
    logic                    wv_q;
    logic [DEPTH_BITS-1:0]   waddr_q;
    logic                    issue;
    logic                    beat_ok;
`ifdef BURST_RESP_GAP_EN
    logic [GAP_CNT_BITS-1:0] gap_cnt_q, gap_cnt_d;
`endif

    // Upper address bits are deliberately ignored: the RAM address wraps.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{wr_burst_addr, rd_burst_addr};

    // A beat is issued (data request or RAM read) in every cycle either flag is set.
    assign issue = wr_req_q | rd_re_q;

    // Next-state, beat sequencing and finish generation.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        left_d   = left_q;
        wr_req_d = 1'b0;
        rd_re_d  = 1'b0;
        wr_fin_d = 1'b0;
        rd_fin_d = 1'b0;
        beat_ok  = 1'b1;
`ifdef BURST_RESP_GAP_EN
        gap_cnt_d = gap_cnt_q;
`endif
        case (state_q)
            IDLE: begin
`ifdef BURST_RESP_GAP_EN
                gap_cnt_d = '0;
`endif
                if (wr_burst_req) begin
                    state_d  = WR;
                    addr_d   = wr_burst_addr[DEPTH_BITS-1:0];
                    left_d   = wr_burst_len;
                    wr_req_d = (wr_burst_len != '0);
                end else if (rd_burst_req) begin
                    state_d  = RD;
                    addr_d   = rd_burst_addr[DEPTH_BITS-1:0];
                    left_d   = rd_burst_len;
                    rd_re_d  = (rd_burst_len != '0);
                end
            end
            WR, RD: begin
                if (issue) begin
                    addr_d = addr_q + DEPTH_BITS'(1);
                    left_d = left_q - BURST_BITS'(1);
                end
`ifdef BURST_RESP_GAP_EN
                if (issue) begin
                    gap_cnt_d = gap_cnt_q + GAP_CNT_BITS'(1);
                end
                beat_ok = !(issue && (gap_cnt_q == GAP_CNT_BITS'(GAP_INTERVAL - 1)));
`endif
                if (left_d != '0) begin
                    // More beats to go: issue next cycle unless a bubble is due.
                    wr_req_d = beat_ok && (state_q == WR);
                    rd_re_d  = beat_ok && (state_q == RD);
                end else if (!issue) begin
                    // Drain cycle after the last beat (or the only cycle for len=0).
                    state_d  = DONE;
                    wr_fin_d = (state_q == WR);
                    rd_fin_d = (state_q == RD);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            left_q     <= '0;
            wr_req_q   <= 1'b0;
            rd_re_q    <= 1'b0;
            wr_fin_q   <= 1'b0;
            rd_fin_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            wv_q       <= 1'b0;
            waddr_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            left_q     <= left_d;
            wr_req_q   <= wr_req_d;
            rd_re_q    <= rd_re_d;
            wr_fin_q   <= wr_fin_d;
            rd_fin_q   <= rd_fin_d;
            rd_valid_q <= rd_re_q;
            wv_q       <= wr_req_q;
            waddr_q    <= addr_q;
        end
    end

`ifdef BURST_RESP_GAP_EN
    // Beat counter that spaces the bubble cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt_q <= '0;
        end else begin
            gap_cnt_q <= gap_cnt_d;
        end
    end
`endif

    burst_resp_ram #(
        .DATA_BITS (MEM_DATA_BITS),
        .ADDR_BITS (DEPTH_BITS)
    ) u_ram (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (wv_q),
        .waddr (waddr_q),
        .wdata (wr_burst_data),
        .re    (rd_re_q),
        .raddr (addr_q),
        .rdata (rd_burst_data)
    );

    assign wr_burst_data_req   = wr_req_q;
    assign wr_burst_finish     = wr_fin_q;
    assign rd_burst_data_valid = rd_valid_q;
    assign rd_burst_finish     = rd_fin_q;

endmodule

// File: tb/tb_burst_mem_responder.sv
// Bench for burst_mem_responder: a schedule-based reference model predicts every
// output per cycle from each accepted request; directed cases pin the model.
module tb_burst_mem_responder;

    localparam int unsigned DW   = 16;
    localparam int unsigned AW   = 24;
    localparam int unsigned BW   = 10;
    localparam int unsigned DB   = 12;
    localparam int unsigned MEMN = 1 << DB;
    localparam int          NCYC = 16384;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_burst_req = 1'b0;
    logic [BW-1:0] wr_burst_len = '0;
    logic [AW-1:0] wr_burst_addr = '0;
    logic          wr_burst_data_req;
    logic [DW-1:0] wr_burst_data = '0;
    logic          wr_burst_finish;
    logic          rd_burst_req = 1'b0;
    logic [BW-1:0] rd_burst_len = '0;
    logic [AW-1:0] rd_burst_addr = '0;
    logic          rd_burst_data_valid;
    logic [DW-1:0] rd_burst_data;
    logic          rd_burst_finish;

    burst_mem_responder #(
        .MEM_DATA_BITS (DW),
        .ADDR_BITS     (AW),
        .BURST_BITS    (BW),
        .DEPTH_BITS    (DB)
    ) dut (
        .clk                 (clk),
        .rst_n               (rst_n),
        .wr_burst_req        (wr_burst_req),
        .wr_burst_len        (wr_burst_len),
        .wr_burst_addr       (wr_burst_addr),
        .wr_burst_data_req   (wr_burst_data_req),
        .wr_burst_data       (wr_burst_data),
        .wr_burst_finish     (wr_burst_finish),
        .rd_burst_req        (rd_burst_req),
        .rd_burst_len        (rd_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .rd_burst_data       (rd_burst_data),
        .rd_burst_finish     (rd_burst_finish)
    );

    always #5 clk = ~clk;

    // Expected per-cycle outputs, filled in when a request is accepted.
    bit            e_wreq [NCYC];
    bit            e_rval [NCYC];
    bit            e_wfin [NCYC];
    bit            e_rfin [NCYC];
    logic [DW-1:0] e_rdat [NCYC];
    bit            e_rknown [NCYC];
    bit            wp_v [NCYC];
    logic [DW-1:0] wp_d [NCYC];
    int            wa_a [NCYC];
    logic [DW-1:0] mmem [MEMN];
    bit            mknown [MEMN];

    int            cyc = 0;
    int            n_cmp = 0;
    int            n_bad = 0;
    int            free_from = 0;
    int            acc_wr, acc_rd, fin_wr, fin_rd;
    logic [DW-1:0] wbeat [$];
    logic [DW-1:0] cur_rd = '0;
    bit            cur_known = 1'b1;

    int            obs_wreq, obs_rval, obs_wfin_cyc, obs_rfin_cyc, obs_rfin_cnt;
    logic [DW-1:0] rcap [$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
        end
    endtask

    // Plan a burst: beats go back to back from T+1, with a bubble after every
    // 8th beat when the gap option is built; finish two cycles after the last beat.
    task automatic model_accept(input bit is_wr, input int t_acc, input int len, input int addr);
        int t, s, a, f;
        t = t_acc + 1;
        for (int i = 0; i < len; i++) begin
            s = t;
            t++;
`ifdef BURST_RESP_GAP_EN
            if (((i + 1) % 8) == 0 && (i + 1) < len) t++;
`endif
            a = (addr + i) % MEMN;
            if (s + 1 < NCYC) begin
                if (is_wr) begin
                    e_wreq[s]  = 1'b1;
                    wp_v[s+1]  = 1'b1;
                    wp_d[s+1]  = (i < wbeat.size()) ? wbeat[i] : DW'($urandom);
                    wa_a[s+1]  = a;
                end else begin
                    e_rval[s+1]   = 1'b1;
                    e_rdat[s+1]   = mmem[a];
                    e_rknown[s+1] = mknown[a];
                end
            end
        end
        f = t + 1;
        if (f < NCYC) begin
            if (is_wr) e_wfin[f] = 1'b1;
            else       e_rfin[f] = 1'b1;
        end
        free_from = f + 1;
        if (is_wr) fin_wr = f;
        else       fin_rd = f;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Write data driver: the planned word in its sample cycle, noise otherwise.
    initial forever begin
        @(posedge clk);
        #1;
        wr_burst_data = (cyc < NCYC && wp_v[cyc]) ? wp_d[cyc] : DW'($urandom);
    end

    // Reference model update and per-cycle compare.
    initial forever begin
        int k;
        @(negedge clk);
        k = cyc;
        if (k >= NCYC) begin
            check("cycle_budget", 32'(k), 32'(NCYC - 1));
            $fatal(1, "cycle budget exhausted");
        end
        if (!rst_n) begin
            check("rst_wreq", 32'(wr_burst_data_req), 32'd0);
            check("rst_wfin", 32'(wr_burst_finish), 32'd0);
            check("rst_rval", 32'(rd_burst_data_valid), 32'd0);
            check("rst_rfin", 32'(rd_burst_finish), 32'd0);
            check("rst_rdat", 32'(rd_burst_data), 32'd0);
            for (int j = k; j < NCYC; j++) begin
                e_wreq[j] = 0; e_rval[j] = 0; e_wfin[j] = 0; e_rfin[j] = 0;
                wp_v[j] = 0;
            end
            cur_rd = '0;
            cur_known = 1'b1;
            free_from = k + 1;
        end else begin
            if (wp_v[k]) begin
                mmem[wa_a[k]]   = wp_d[k];
                mknown[wa_a[k]] = 1'b1;
            end
            if (e_rval[k]) begin
                cur_rd    = e_rdat[k];
                cur_known = e_rknown[k];
            end
            check("wr_data_req", 32'(wr_burst_data_req), 32'(e_wreq[k]));
            check("wr_finish", 32'(wr_burst_finish), 32'(e_wfin[k]));
            check("rd_valid", 32'(rd_burst_data_valid), 32'(e_rval[k]));
            check("rd_finish", 32'(rd_burst_finish), 32'(e_rfin[k]));
            if (cur_known) check("rd_data", 32'(rd_burst_data), 32'(cur_rd));
            if (wr_burst_data_req) obs_wreq++;
            if (wr_burst_finish) obs_wfin_cyc = k;
            if (rd_burst_finish) begin obs_rfin_cyc = k; obs_rfin_cnt++; end
            if (rd_burst_data_valid) begin obs_rval++; rcap.push_back(rd_burst_data); end
            if (k >= free_from && wr_burst_req) begin
                acc_wr = k;
                model_accept(1'b1, k, int'(wr_burst_len), int'(wr_burst_addr));
            end else if (k >= free_from && rd_burst_req) begin
                acc_rd = k;
                model_accept(1'b0, k, int'(rd_burst_len), int'(rd_burst_addr));
            end
        end
    end

    task automatic clear_obs();
        obs_wreq = 0; obs_rval = 0; obs_wfin_cyc = -1; obs_rfin_cyc = -1; obs_rfin_cnt = 0;
        rcap.delete();
        acc_wr = -1; acc_rd = -1; fin_wr = -1; fin_rd = -1;
    endtask

    // Raise the requested burst(s), hold each until its finish, then release.
    task automatic burst(input bit dw, input bit dr, input int wlen, input int waddr,
                         input int rlen, input int raddr);
        int guard;
        @(posedge clk);
        #1;
        clear_obs();
        wr_burst_req  = dw;
        wr_burst_len  = BW'(wlen);
        wr_burst_addr = AW'(waddr);
        rd_burst_req  = dr;
        rd_burst_len  = BW'(rlen);
        rd_burst_addr = AW'(raddr);
        guard = 0;
        while ((wr_burst_req || rd_burst_req) && guard < 4000) begin
            @(posedge clk);
            #1;
            guard++;
            if (wr_burst_req && fin_wr >= 0 && cyc > fin_wr) wr_burst_req = 1'b0;
            if (rd_burst_req && fin_rd >= 0 && cyc > fin_rd) rd_burst_req = 1'b0;
        end
        check("burst_completed", 32'(wr_burst_req | rd_burst_req), 32'd0);
        wr_burst_req = 1'b0;
        rd_burst_req = 1'b0;
    endtask

    task automatic fill_beats(input int n);
        wbeat.delete();
        for (int i = 0; i < n; i++) wbeat.push_back(DW'($urandom));
    endtask

    initial begin
        int guard, kind, len, lo;
        #2_000_000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int guard, kind, len, lo, addr;
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Populate a window that wraps through the top of the RAM.
        fill_beats(300);
        burst(1, 0, 300, 'hF80, 0, 0);

        // Write then read four words at 0x10.
        wbeat.delete();
        for (int i = 0; i < 4; i++) wbeat.push_back(DW'('hA0 + i));
        burst(1, 0, 4, 'h000010, 0, 0);
        check("d1_wreq_cycles", 32'(obs_wreq), 32'd4);
        check("d1_wfin_offset", 32'(obs_wfin_cyc - acc_wr), 32'd6);
        burst(0, 1, 0, 0, 4, 'h000010);
        check("d1_rfin_offset", 32'(obs_rfin_cyc - acc_rd), 32'd6);
        check("d1_rcount", 32'(rcap.size()), 32'd4);
        for (int i = 0; i < 4 && i < rcap.size(); i++) check("d1_rdata", 32'(rcap[i]), 32'('hA0 + i));

        // Both requests together: write first, read accepted at T+7.
        fill_beats(4);
        burst(1, 1, 4, 'h20, 4, 'h10);
        check("d2_rd_accept", 32'(acc_rd - acc_wr), 32'd7);
        check("d2_no_overlap", 32'(obs_wfin_cyc < acc_rd), 32'd1);
        for (int i = 0; i < 4 && i < rcap.size(); i++) check("d2_rdata", 32'(rcap[i]), 32'('hA0 + i));

        // Address wrap at the top of the RAM; upper address bits ignored on read.
        wbeat.delete();
        wbeat.push_back(16'h1111); wbeat.push_back(16'h2222); wbeat.push_back(16'h3333);
        burst(1, 0, 3, 'h000FFF, 0, 0);
        burst(0, 1, 0, 0, 2, 'hABC000);
        check("d3_rcount", 32'(rcap.size()), 32'd2);
        if (rcap.size() == 2) begin
            check("d3_rdata0", 32'(rcap[0]), 32'h2222);
            check("d3_rdata1", 32'(rcap[1]), 32'h3333);
        end

        // Zero-length read.
        burst(0, 1, 0, 0, 0, 'h40);
        check("d4_rval_cycles", 32'(obs_rval), 32'd0);
        check("d4_rfin_offset", 32'(obs_rfin_cyc - acc_rd), 32'd2);

        // Twenty-beat read: bubbles only when the gap option is built.
        burst(0, 1, 0, 0, 20, 'hF90);
        check("d5_rval_cycles", 32'(obs_rval), 32'd20);
`ifdef BURST_RESP_GAP_EN
        check("d5_rfin_offset", 32'(obs_rfin_cyc - acc_rd), 32'd24);
`else
        check("d5_rfin_offset", 32'(obs_rfin_cyc - acc_rd), 32'd22);
`endif

        // Reset in the middle of a sixteen-beat read.
        @(posedge clk);
        #1;
        clear_obs();
        rd_burst_req  = 1'b1;
        rd_burst_len  = BW'(16);
        rd_burst_addr = AW'('hF90);
        guard = 0;
        while (!(acc_rd >= 0 && cyc >= acc_rd + 7) && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        #1;
        rst_n = 1'b0;
        rd_burst_req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("d6_beats_before_rst", 32'(obs_rval), 32'd5);
        repeat (30) @(posedge clk);
        check("d6_no_finish", 32'(obs_rfin_cnt), 32'd0);
        burst(0, 1, 0, 0, 3, 'hF90);
        check("d6_rfin_offset", 32'(obs_rfin_cyc - acc_rd), 32'd5);

        // Random traffic inside the populated window.
        for (int n = 0; n < 40; n++) begin
            kind = $urandom_range(0, 2);
            len  = $urandom_range(0, 60);
            lo   = ('hF80 + $urandom_range(0, 200)) % MEMN;
            addr = int'($urandom & 32'hFFF000) | lo;
            fill_beats(len);
            case (kind)
                0: burst(1, 0, len, addr, 0, 0);
                1: burst(0, 1, 0, 0, len, addr);
                default: burst(1, 1, len, addr, $urandom_range(0, 60),
                               int'($urandom & 32'hFFF000) | (('hF80 + $urandom_range(0, 200)) % MEMN));
            endcase
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
